checkbits_seq_monitor: RTL and testbench

//  Parametrised, synthesizable successor to the bench-level "wait(checkbits==X)" chain. Watches the

---
 rtl/checkbits_mon_pkg.sv | 23 ++
 rtl/cycle_timeout_ctr.sv | 28 ++
 rtl/checkbits_seq_monitor.sv | 205 ++++++++++++++++++++
 tb/tb_checkbits_seq_monitor.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/checkbits_mon_pkg.sv
// rtl/checkbits_mon_pkg.sv - shared types and default tags for the checkbits sequence monitor
package checkbits_mon_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_START,
      SEQ,
      WAIT_END,
      DONE
   } mon_state_t;

   typedef enum logic [1:0] {
      RES_NONE,
      RES_PASS,
      RES_TIMEOUT,
      RES_MISMATCH
   } mon_result_t;

   localparam logic [15:0] DEF_START_TAG = 16'hAB40;
   localparam logic [15:0] DEF_END_TAG   = 16'hAB51;
   localparam int          DEF_TIMEOUT   = 500000;

endpackage

// File: rtl/cycle_timeout_ctr.sv
// rtl/cycle_timeout_ctr.sv - busy-cycle counter that flags expiry one cycle short of the limit
// clear loads 1 because the cycle that arms the monitor already counts as busy.
module cycle_timeout_ctr #(
   parameter int CW = 20
) (
   input  logic          clock,
   input  logic          resetb,
   input  logic          clear,
   input  logic          enable,
   input  logic [CW-1:0] limit,
   output logic          expired
);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         r_cnt <= '0;
      end else if (clear) begin
         r_cnt <= CW'(1);
      end else if (enable) begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   assign expired = enable && (r_cnt >= limit - CW'(1));

endmodule

// File: rtl/checkbits_seq_monitor.sv
// rtl/checkbits_seq_monitor.sv - start tag / expected-value table / end tag matcher with timeout
// Optional CHECKBITS_MON_STABLE_EN: matches require chk_q to hold STABLE_CYC cycles.
module checkbits_seq_monitor
   import checkbits_mon_pkg::*;
#(
   parameter int           W         = 16,
   parameter int           DEPTH     = 16,
   parameter logic [W-1:0] START_TAG = W'(DEF_START_TAG),
   parameter logic [W-1:0] END_TAG   = W'(DEF_END_TAG),
   parameter int           TIMEOUT   = DEF_TIMEOUT
`ifdef CHECKBITS_MON_STABLE_EN
   ,parameter int          STABLE_CYC = 4
`endif
) (
   input  logic                     clock,
   input  logic                     resetb,
   input  logic                     start,
   input  logic                     abort,
   input  logic                     strict,
   input  logic [W-1:0]             checkbits,
   input  logic                     exp_we,
   input  logic [$clog2(DEPTH)-1:0] exp_addr,
   input  logic [W-1:0]             exp_wdata,
   input  logic [$clog2(DEPTH):0]   exp_len,
   output logic                     busy,
   output logic                     match_pulse,
   output logic [$clog2(DEPTH):0]   match_idx,
   output logic                     done,
   output logic                     pass,
   output logic                     fail_timeout,
   output logic                     fail_mismatch,
   output logic [W-1:0]             bad_value
);

   localparam int AW = $clog2(DEPTH);
   localparam int IW = AW + 1;
   localparam int CW = $clog2(TIMEOUT + 1);

   logic [W-1:0]  r_table [DEPTH];
   logic [W-1:0]  r_chk_q, r_chk_d1, r_last, r_bad_value;
   mon_state_t    r_state;
   logic [IW-1:0] r_len, r_idx;
   logic          r_strict, r_busy, r_match_pulse, r_done, r_pass, r_fail_timeout, r_fail_mismatch;

   logic          w_arm, w_expired, w_changed, w_qual, w_eval;
   logic          w_start_hit, w_hit, w_miss;
   logic [W-1:0]  w_target;
   logic [IW-1:0] w_len_clamped;
   mon_result_t   w_res;

   always_ff @(posedge clock) begin
      if (exp_we && !r_busy) r_table[exp_addr] <= exp_wdata;
   end

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         r_chk_q  <= '0;
         r_chk_d1 <= '0;
      end else begin
         r_chk_q  <= checkbits;
         r_chk_d1 <= r_chk_q;
      end
   end

   assign w_changed = (r_chk_q != r_chk_d1);

`ifdef CHECKBITS_MON_STABLE_EN
   localparam int SW = $clog2(STABLE_CYC + 1);
   logic [SW-1:0] r_stab, w_hold;
   logic          w_match_evt;

   always_comb begin
      w_hold = '0;
      if (w_changed)                      w_hold = SW'(1);
      else if (r_stab == SW'(STABLE_CYC)) w_hold = r_stab;
      else                                w_hold = r_stab + SW'(1);
   end

   assign w_match_evt = ((r_state == WAIT_START) && w_start_hit) ||
                        (((r_state == SEQ) || (r_state == WAIT_END)) && w_hit);

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) r_stab <= '0;
      else         r_stab <= w_match_evt ? '0 : w_hold;
   end

   assign w_qual = (w_hold >= SW'(STABLE_CYC));
   assign w_eval = w_qual;
`else
   assign w_qual = 1'b1;
   assign w_eval = w_changed;
`endif

   assign w_arm         = start && !abort && ((r_state == IDLE) || (r_state == DONE));
   assign w_len_clamped = (exp_len > IW'(DEPTH)) ? IW'(DEPTH) : exp_len;

   cycle_timeout_ctr #(.CW(CW)) u_timer (
      .clock   (clock),
      .resetb  (resetb),
      .clear   (w_arm),
      .enable  (r_busy),
      .limit   (CW'(TIMEOUT)),
      .expired (w_expired)
   );

   // SEQ never reaches idx==len, so the table index is always in range there.
   always_comb begin
      w_target    = (r_state == WAIT_END) ? END_TAG : r_table[r_idx[AW-1:0]];
      w_start_hit = w_qual && (r_chk_q == START_TAG);
      w_hit       = w_qual && (r_chk_q == w_target);
      w_miss      = r_strict && w_eval && (r_chk_q != w_target) && (r_chk_q != r_last);
      w_res       = RES_NONE;
      case (r_state)
         WAIT_START: if (!w_start_hit && w_expired) w_res = RES_TIMEOUT;
         SEQ: begin
            if (!w_hit) begin
               if (w_miss)         w_res = RES_MISMATCH;
               else if (w_expired) w_res = RES_TIMEOUT;
            end
         end
         WAIT_END: begin
            if (w_hit)          w_res = RES_PASS;
            else if (w_miss)    w_res = RES_MISMATCH;
            else if (w_expired) w_res = RES_TIMEOUT;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         r_state         <= IDLE;
         r_len           <= '0;
         r_idx           <= '0;
         r_last          <= '0;
         r_strict        <= 1'b0;
         r_busy          <= 1'b0;
         r_match_pulse   <= 1'b0;
         r_done          <= 1'b0;
         r_pass          <= 1'b0;
         r_fail_timeout  <= 1'b0;
         r_fail_mismatch <= 1'b0;
         r_bad_value     <= '0;
      end else begin
         r_match_pulse <= 1'b0;
         if (abort) begin
            r_state         <= IDLE;
            r_busy          <= 1'b0;
            r_idx           <= '0;
            r_done          <= 1'b0;
            r_pass          <= 1'b0;
            r_fail_timeout  <= 1'b0;
            r_fail_mismatch <= 1'b0;
            r_bad_value     <= '0;
         end else if (w_arm) begin
            r_state         <= WAIT_START;
            r_busy          <= 1'b1;
            r_len           <= w_len_clamped;
            r_strict        <= strict;
            r_idx           <= '0;
            r_done          <= 1'b0;
            r_pass          <= 1'b0;
            r_fail_timeout  <= 1'b0;
            r_fail_mismatch <= 1'b0;
            r_bad_value     <= '0;
         end else if (w_res != RES_NONE) begin
            r_state         <= DONE;
            r_busy          <= 1'b0;
            r_done          <= 1'b1;
            r_pass          <= (w_res == RES_PASS);
            r_fail_timeout  <= (w_res == RES_TIMEOUT);
            r_fail_mismatch <= (w_res == RES_MISMATCH);
            if (w_res == RES_MISMATCH) r_bad_value <= r_chk_q;
         end else begin
            case (r_state)
               WAIT_START: begin
                  if (w_start_hit) begin
                     r_last  <= START_TAG;
                     r_state <= (r_len == '0) ? WAIT_END : SEQ;
                  end
               end
               SEQ: begin
                  if (w_hit) begin
                     r_match_pulse <= 1'b1;
                     r_idx         <= r_idx + IW'(1);
                     r_last        <= w_target;
                     if (r_idx + IW'(1) == r_len) r_state <= WAIT_END;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign busy          = r_busy;
   assign match_pulse   = r_match_pulse;
   assign match_idx     = r_idx;
   assign done          = r_done;
   assign pass          = r_pass;
   assign fail_timeout  = r_fail_timeout;
   assign fail_mismatch = r_fail_mismatch;
   assign bad_value     = r_bad_value;

endmodule

// File: tb/tb_checkbits_seq_monitor.sv
// tb/tb_checkbits_seq_monitor.sv - directed self-checking bench for checkbits_seq_monitor
module tb_checkbits_seq_monitor;

   localparam int W       = 16;
   localparam int DEPTH   = 16;
   localparam int AW      = 4;
   localparam int IW      = 5;
   localparam int TIMEOUT = 1000;
`ifdef CHECKBITS_MON_STABLE_EN
   localparam int EXTRA   = 3;
`else
   localparam int EXTRA   = 0;
`endif

   logic          clock, resetb, start, abort, strict, exp_we;
   logic [W-1:0]  checkbits, exp_wdata, bad_value;
   logic [AW-1:0] exp_addr;
   logic [IW-1:0] exp_len, match_idx;
   logic          busy, match_pulse, done, pass, fail_timeout, fail_mismatch;

   int n_pass = 0;
   int n_fail = 0;
   int n_total = 0;
   int pulse_cnt = 0;
   int base;
   int fir_i [11] = '{0, -10, -29, -25, 35, 158, 337, 539, 732, 915, 1098};

   checkbits_seq_monitor #(
      .W(W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
`ifdef CHECKBITS_MON_STABLE_EN
      , .STABLE_CYC(4)
`endif
   ) dut (
      .clock(clock), .resetb(resetb), .start(start), .abort(abort), .strict(strict),
      .checkbits(checkbits), .exp_we(exp_we), .exp_addr(exp_addr), .exp_wdata(exp_wdata),
      .exp_len(exp_len), .busy(busy), .match_pulse(match_pulse), .match_idx(match_idx),
      .done(done), .pass(pass), .fail_timeout(fail_timeout), .fail_mismatch(fail_mismatch),
      .bad_value(bad_value)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(negedge clock) if (match_pulse === 1'b1) pulse_cnt++;

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic present(input logic [15:0] v, input int n);
      checkbits = v;
      repeat (n) tick;
   endtask

   task automatic write_entry(input int a, input logic [15:0] v);
      exp_we = 1'b1; exp_addr = AW'(a); exp_wdata = v;
      tick;
      exp_we = 1'b0;
   endtask

   task automatic write_fir;
      for (int i = 0; i < 11; i++) write_entry(i, 16'(fir_i[i]));
   endtask

   task automatic arm(input int len, input logic s);
      exp_len = IW'(len); strict = s; start = 1'b1;
      tick;
      start = 1'b0;
   endtask

   task automatic run_fir;
      present(16'h7777, 1);
      present(16'hAB40, 2 + EXTRA);
      for (int i = 0; i < 11; i++) begin
         present(16'h7777, 1);
         present(16'(fir_i[i]), 2 + EXTRA);
      end
      present(16'h7777, 1);
      present(16'hAB51, 2 + EXTRA);
   endtask

   initial begin
      resetb = 1'b0; start = 1'b0; abort = 1'b0; strict = 1'b0; exp_we = 1'b0;
      exp_addr = '0; exp_wdata = '0; exp_len = '0; checkbits = 16'h1111;
      tick; tick;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_pass", pass, 0);
      chk("rst_idx", match_idx, 0);
      chk("rst_fails", {fail_timeout, fail_mismatch}, 0);
      resetb = 1'b1;
      tick;

      // 1: relaxed FIR sequence with glitches, plus match latency on the first entry
      write_fir;
      checkbits = 16'h1111;
      arm(11, 1'b0);
      chk("t1_busy", busy, 1);
      base = pulse_cnt;
      present(16'hAB40, 2 + EXTRA);
      present(16'h7777, 1);
      checkbits = 16'h0000;
      repeat (1 + EXTRA) tick;
      chk("t1_lat_early", match_pulse, 0);
      tick;
      chk("t1_lat_pulse", match_pulse, 1);
      chk("t1_lat_idx", match_idx, 1);
      for (int i = 1; i < 11; i++) begin
         present(16'h7777, 1);
         present(16'(fir_i[i]), 2 + EXTRA);
      end
      chk("t1_busy_wait_end", busy, 1);
      present(16'h7777, 1);
      present(16'hAB51, 2 + EXTRA);
      chk("t1_pulses", pulse_cnt - base, 11);
      chk("t1_idx", match_idx, 11);
      chk("t1_pass", pass, 1);
      chk("t1_done", done, 1);
      chk("t1_busy_off", busy, 0);
      chk("t1_fails", {fail_timeout, fail_mismatch}, 0);
      tick; tick;
      chk("t1_done_sticky", done, 1);

      // 2: timeout, start tag never shown
      checkbits = 16'h1111;
      arm(11, 1'b0);
      repeat (998) tick;
      chk("t2_not_yet", fail_timeout, 0);
      chk("t2_still_busy", busy, 1);
      tick;
      chk("t2_timeout", fail_timeout, 1);
      chk("t2_done", done, 1);
      chk("t2_pass", pass, 0);
      chk("t2_busy", busy, 0);

      // 3: strict mismatch after first entry
      checkbits = 16'h1111;
      arm(11, 1'b1);
      present(16'hAB40, 2 + EXTRA);
      present(16'h0000, 2 + EXTRA);
      chk("t3_idx1", match_idx, 1);
      present(16'h1234, 1 + EXTRA);
      chk("t3_not_yet", fail_mismatch, 0);
      tick;
      chk("t3_mismatch", fail_mismatch, 1);
      chk("t3_bad", bad_value, 16'h1234);
      chk("t3_idx", match_idx, 1);
      chk("t3_done", done, 1);
      chk("t3_pass", pass, 0);
      chk("t3_timeout", fail_timeout, 0);

      // 4a: zero-length table
      checkbits = 16'h1111;
      base = pulse_cnt;
      arm(0, 1'b0);
      present(16'hAB40, 2 + EXTRA);
      chk("t4a_busy", busy, 1);
      present(16'hAB51, 2 + EXTRA);
      chk("t4a_pass", pass, 1);
      chk("t4a_idx", match_idx, 0);
      chk("t4a_pulses", pulse_cnt - base, 0);

      // 4b: duplicate consecutive entries
      write_entry(0, 16'd5);
      write_entry(1, 16'd5);
      checkbits = 16'h1111;
      arm(2, 1'b0);
      present(16'hAB40, 2 + EXTRA);
      present(16'd5, 2 + EXTRA);
      chk("t4b_idx1", match_idx, 1);
      chk("t4b_pulse1", match_pulse, 1);
      repeat (1 + EXTRA) tick;
      chk("t4b_idx2", match_idx, 2);
      chk("t4b_pulse2", match_pulse, 1);
      present(16'hAB51, 2 + EXTRA);
      chk("t4b_pass", pass, 1);

      // 5: abort mid-SEQ, reset mid-SEQ, then a full pass with the retained table
      write_fir;
      checkbits = 16'h1111;
      arm(11, 1'b0);
      present(16'hAB40, 2 + EXTRA);
      present(16'h0000, 2 + EXTRA);
      present(16'(fir_i[1]), 2 + EXTRA);
      chk("t5_idx_before_abort", match_idx, 2);
      abort = 1'b1;
      tick;
      abort = 1'b0;
      chk("t5_abort_busy", busy, 0);
      chk("t5_abort_flags", {done, pass, fail_timeout, fail_mismatch}, 0);
      chk("t5_abort_idx", match_idx, 0);
      checkbits = 16'h1111;
      arm(11, 1'b0);
      present(16'hAB40, 2 + EXTRA);
      present(16'h0000, 2 + EXTRA);
      resetb = 1'b0;
      #1;
      chk("t5_rst_busy", busy, 0);
      chk("t5_rst_idx", match_idx, 0);
      chk("t5_rst_flags", {done, pass, fail_timeout, fail_mismatch}, 0);
      tick;
      resetb = 1'b1;
      tick;
      checkbits = 16'h1111;
      base = pulse_cnt;
      arm(11, 1'b0);
      run_fir;
      chk("t5_rerun_pass", pass, 1);
      chk("t5_rerun_idx", match_idx, 11);
      chk("t5_rerun_pulses", pulse_cnt - base, 11);

`ifdef CHECKBITS_MON_STABLE_EN
      // 6: a 3-cycle entry pulse is too short, a 4-cycle hold matches
      checkbits = 16'h1111;
      base = pulse_cnt;
      arm(11, 1'b0);
      present(16'hAB40, 2 + EXTRA);
      present(16'h0000, 3);
      present(16'h7777, 3);
      chk("t6_short_idx", match_idx, 0);
      chk("t6_short_pulses", pulse_cnt - base, 0);
      present(16'h0000, 2 + EXTRA);
      chk("t6_hold_idx", match_idx, 1);
      abort = 1'b1;
      tick;
      abort = 1'b0;
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
